// File: rtl/alu.sv
// Single-cycle integer ALU / address generator for the issue stage; result and tag registered.
// Latency 1 cycle, a new op every cycle; no stall or backpressure, consumers qualify on result_valid.
module alu (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic [5:0]  dest_i,
   output logic [31:0] result,
   output logic [5:0]  result_dest,
   output logic        result_valid
);

   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;

   logic [31:0] sum;
   logic [31:0] diff;
   logic [4:0]  shamt;
   logic [31:0] alu_res;

   // One shared adder feeds ADD/ADDI and the LW/SW address path.
   assign sum   = src1 + src2;
   assign diff  = src1 - src2;
   assign shamt = src2[4:0];

   always_comb begin
      alu_res = '0;
      case (opcode)
         OP_IMM: begin
            case (func3)
               3'b000:  alu_res = sum;
               3'b100:  alu_res = src1 ^ src2;
               3'b110:  alu_res = src1 | src2;
               3'b111:  alu_res = src1 & src2;
               default: alu_res = '0;
            endcase
         end
         OP_REG: begin
            case (func3)
               3'b000: begin
                  if (func7 == F7_BASE)
                     alu_res = sum;
                  else if (func7 == F7_ALT)
                     alu_res = diff;
               end
               3'b001:  alu_res = src1 << shamt;
               3'b100:  alu_res = src1 ^ src2;
               3'b101: begin
                  if (func7 == F7_BASE)
                     alu_res = src1 >> shamt;
                  else if (func7 == F7_ALT)
                     alu_res = $unsigned($signed(src1) >>> shamt);
               end
               3'b110:  alu_res = src1 | src2;
               3'b111:  alu_res = src1 & src2;
               default: alu_res = '0;
            endcase
         end
         OP_LOAD, OP_STORE: alu_res = sum;
         default:           alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result       <= '0;
         result_dest  <= '0;
         result_valid <= 1'b0;
      end else begin
         result       <= alu_res;
         result_dest  <= dest_i;
         result_valid <= valid_i;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations queued at drive time, checked one edge later.
module tb_alu;

   logic        clk;
   logic        rst;
   logic        valid_i;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [5:0]  dest_i;
   logic [31:0] result;
   logic [5:0]  result_dest;
   logic        result_valid;

   alu dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .opcode       (opcode),
      .func3        (func3),
      .func7        (func7),
      .src1         (src1),
      .src2         (src2),
      .dest_i       (dest_i),
      .result       (result),
      .result_dest  (result_dest),
      .result_valid (result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [5:0]  dest;
      logic [31:0] res;
      logic        full;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   localparam logic [6:0] I_OP = 7'b0010011;
   localparam logic [6:0] R_OP = 7'b0110011;
   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] BR   = 7'b1100011;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Reference behaviour written from the instruction definitions.
   function automatic logic [31:0] model(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] a,
                                         input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      if (op == LW || op == SW) return a + b;
      if (op == I_OP) begin
         if (f3 == 3'd0) return a + b;
         if (f3 == 3'd4) return a ^ b;
         if (f3 == 3'd6) return a | b;
         if (f3 == 3'd7) return a & b;
         return 32'd0;
      end
      if (op == R_OP) begin
         if (f3 == 3'd0 && f7 == 7'h00) return a + b;
         if (f3 == 3'd0 && f7 == 7'h20) return a - b;
         if (f3 == 3'd1) return a << sh;
         if (f3 == 3'd4) return a ^ b;
         if (f3 == 3'd5 && f7 == 7'h00) return a >> sh;
         if (f3 == 3'd5 && f7 == 7'h20) return $unsigned($signed(a) >>> sh);
         if (f3 == 3'd6) return a | b;
         if (f3 == 3'd7) return a & b;
         return 32'd0;
      end
      return 32'd0;
   endfunction

   // Drive one cycle of stimulus on the falling edge and queue what must appear after the next rise.
   task automatic drive(input string tag, input logic r, input logic v, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] d, input logic [31:0] want);
      exp_t e;
      @(negedge clk);
      rst = r; valid_i = v; opcode = op; func3 = f3; func7 = f7;
      src1 = a; src2 = b; dest_i = d;
      if (r) begin
         e.vld = 1'b0; e.dest = '0; e.res = '0; e.full = 1'b1;
      end else begin
         e.vld = v; e.dest = d; e.res = want; e.full = v;
      end
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t  e;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check({t, ".valid"}, {31'd0, result_valid}, {31'd0, e.vld});
         if (e.full) begin
            check({t, ".result"}, result, e.res);
            check({t, ".dest"}, {26'd0, result_dest}, {26'd0, e.dest});
         end
      end
   end

   initial begin
      rst = 1'b1; valid_i = 1'b0; opcode = '0; func3 = '0; func7 = '0;
      src1 = '0; src2 = '0; dest_i = '0;

      drive("rst0", 1, 1, R_OP, 3'd0, 7'h00, 32'd5, 32'd3, 6'd7, 32'd0);
      drive("rst1", 1, 1, R_OP, 3'd0, 7'h00, 32'd5, 32'd3, 6'd7, 32'd0);
      drive("post_rst_add", 0, 1, R_OP, 3'd0, 7'h00, 32'd5, 32'd3, 6'd7, 32'd8);

      drive("addi", 0, 1, I_OP, 3'd0, 7'h00, 32'h10, 32'hFFF, 6'd12, 32'h0000100F);
      drive("andi", 0, 1, I_OP, 3'd7, 7'h00, 32'h10, 32'hFFF, 6'd13, 32'h00000010);
      drive("add_wrap", 0, 1, R_OP, 3'd0, 7'h00, 32'hFFFFFFFF, 32'd1, 6'd20, 32'h0);
      drive("sub_wrap", 0, 1, R_OP, 3'd0, 7'h20, 32'd0, 32'd1, 6'd21, 32'hFFFFFFFF);
      drive("xor", 0, 1, R_OP, 3'd4, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 6'd22, 32'h0FF00FF0);
      drive("sra", 0, 1, R_OP, 3'd5, 7'h20, 32'h80000010, 32'd4, 6'd23, 32'hF8000001);
      drive("srl", 0, 1, R_OP, 3'd5, 7'h00, 32'h80000010, 32'd4, 6'd24, 32'h08000001);
      drive("sll36", 0, 1, R_OP, 3'd1, 7'h00, 32'h80000010, 32'd36, 6'd25, 32'h00000100);
      drive("lw", 0, 1, LW, 3'd2, 7'h00, 32'h1000, 32'h24, 6'd26, 32'h00001024);
      drive("sw", 0, 1, SW, 3'd2, 7'h5A, 32'h2000, 32'h8, 6'd27, 32'h00002008);
      drive("branch", 0, 1, BR, 3'd0, 7'h00, 32'h1234, 32'h1, 6'd28, 32'h0);
      drive("bad_f7", 0, 1, R_OP, 3'd0, 7'h01, 32'h1234, 32'h1, 6'd29, 32'h0);
      drive("bad_f3i", 0, 1, I_OP, 3'd1, 7'h00, 32'h1234, 32'h1, 6'd30, 32'h0);

      drive("pipe_add", 0, 1, R_OP, 3'd0, 7'h00, 32'd100, 32'd23, 6'd1, 32'd123);
      drive("pipe_sub", 0, 1, R_OP, 3'd0, 7'h20, 32'd100, 32'd23, 6'd2, 32'd77);
      drive("pipe_xor", 0, 1, R_OP, 3'd4, 7'h00, 32'hAAAA5555, 32'hFFFF0000, 6'd3, 32'h55555555);
      drive("idle", 0, 0, R_OP, 3'd0, 7'h00, 32'd1, 32'd1, 6'd4, 32'd0);

      for (int i = 0; i < 40; i++) begin
         logic [6:0]  op;
         logic [2:0]  f3;
         logic [6:0]  f7;
         logic [31:0] a;
         logic [31:0] b;
         logic        v;
         case ($urandom_range(0, 4))
            0: op = I_OP;
            1, 2: op = R_OP;
            3: op = ($urandom_range(0, 1) != 0) ? LW : SW;
            default: op = BR;
         endcase
         f3 = 3'($urandom_range(0, 7));
         f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
         a  = $urandom;
         b  = $urandom;
         v  = ($urandom_range(0, 5) != 0);
         drive($sformatf("rnd%0d", i), 0, v, op, f3, f7, a, b, 6'($urandom_range(0, 63)),
               model(op, f3, f7, a, b));
      end

      drive("rst_mid", 1, 1, I_OP, 3'd0, 7'h00, 32'd9, 32'd9, 6'd44, 32'd0);
      drive("after_rst", 0, 1, I_OP, 3'd6, 7'h00, 32'hF0, 32'h0F, 6'd45, 32'hFF);

      @(negedge clk);
      valid_i = 1'b0;
      repeat (3) @(negedge clk);
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
